ym3438_host_writer: RTL
=======================

# ym3438_host_writer

Bus-master sequencer that drives the YM3438 CPU port (CS/WR/RD/ADDRESS/DATA) from a simple register-write request stream. Each request is a two-step access: address write, then data write. Unless the request bypasses it, the block then polls the status byte until busy (bit 7) clears or a poll limit expires. It sits between a host or test driver (sound-driver CPU model, register playback engine) and the `ym3438` instance, clocked on MCLK.

## Interface
- `SETUP`, 1: cycles CS low with strobes high before each strobe; range 1..255.
- `STROBE`, 4: cycles WR or RD held low; range 1..255.
- `GAP`, 2: cycles CS/WR/RD all high after each strobe; range 1..255.
- `POLL_LIMIT`, 64: maximum status reads per request; range 1..65535.
- `MCLK`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle; request accepted when `req_valid & req_ready`.
- `req_port`  in  1  register bank (0: ports 0/1, 1: ports 2/3).
- `req_addr`  in  8  register address.
- `req_data`  in  8  register value.
- `req_nopoll`  in  1  skip busy polling for this request.
- `CS`, `WR`, `RD`  out  1 each  active-low chip strobes.
- `ADDRESS`  out  2  chip A1:A0.
- `DATA`  out  8  byte to chip `DATA_i`.
- `DATA_i`  in  8  byte from chip `DATA_o`; bit 7 = busy.
- `wr_done`  out  1  one-cycle pulse, request finished.
- `wr_timeout`  out  1  valid with `wr_done`; poll limit exhausted while busy.
- `busy_seen`  out  1  level; last sampled busy bit.

## Operation
- States: IDLE, A_SETUP, A_STROBE, A_GAP, D_SETUP, D_STROBE, D_GAP, P_SETUP, P_STROBE, P_GAP. An 8-bit phase counter and a 16-bit poll counter drive the sequence.
- IDLE: `req_ready`=1. `CS`=`WR`=`RD`=1. On accept, latch port/addr/data/nopoll. Clear the poll counter. Go to A_SETUP.
- Address phase:
  - `ADDRESS`={port,0}, `DATA`=addr.
  - `CS`=0 in A_SETUP and A_STROBE.
  - `WR`=0 in A_STROBE only.
  - `CS`=1 in A_GAP.
- Data phase: identical to the address phase, with `ADDRESS`={port,1} and `DATA`=data.
- After D_GAP: if nopoll, go to IDLE with a `wr_done` pulse. Otherwise go to P_SETUP.
- Poll phase:
  - `ADDRESS`=00, `CS`=0 in P_SETUP and P_STROBE.
  - `RD`=0 in P_STROBE.
  - `DATA_i[7]` is sampled into `busy_seen` on the last P_STROBE cycle, and the poll counter increments.
- After P_GAP:
  - busy=0: IDLE, `wr_done`=1, `wr_timeout`=0.
  - busy=1 and count<POLL_LIMIT: P_SETUP.
  - busy=1 and count=POLL_LIMIT: IDLE, `wr_done`=1, `wr_timeout`=1.
- `WR` and `RD` are never low together. `ADDRESS`/`DATA` change only while `CS`=1 or at a SETUP boundary, never while a strobe is low.
- Requests arriving while `req_ready`=0 are held by the requester; none are dropped.

## Timing
- Reset values: `req_ready`=1, `CS`=`WR`=`RD`=1, `ADDRESS`=0, `DATA`=0, `wr_done`=0, `wr_timeout`=0, `busy_seen`=0, state IDLE.
- All outputs are registered.
- Accept at cycle T. First A_SETUP is at T+1.
- Each access lasts SETUP+STROBE+GAP cycles.
- nopoll latency: `wr_done` at T+1+2·(S+W+G). With defaults, T+15.
- Poll latency: one access per poll. With defaults and one non-busy poll, `wr_done` at T+22.
- `wr_done` is asserted in the same cycle the block returns to IDLE, with `req_ready`=1. A new request may be accepted in that cycle.
- Reset mid-operation:
  - Strobes go high and the state returns to IDLE at the next edge.
  - The latched request is discarded.
  - No `wr_done` pulse is produced.
- Poll-count wrap is impossible: the terminate check precedes any overflow.

## Test plan
- Write port 0, addr 0x28, data 0xF0, nopoll=1, defaults:
  - cycles T+1..T+7: `ADDRESS`=00, `DATA`=0x28; `WR` low T+2..T+5.
  - cycles T+8..T+14: `ADDRESS`=01, `DATA`=0xF0.
  - `wr_done` at T+15.
- Same write with nopoll=0 and a chip model returning busy=0: `RD` low T+16..T+19, `wr_done` at T+22, `wr_timeout`=0.
- Busy model holds bit 7 high for 3 polls: exactly 4 read strobes, `busy_seen`=0 at end, `wr_done` at T+43.
- POLL_LIMIT=2 with busy stuck at 1: 2 reads, then `wr_done`=1 with `wr_timeout`=1 and `busy_seen`=1.
- Port 1, addr 0xB4, data 0xC0: address phase `ADDRESS`=10, data phase `ADDRESS`=11. Back-to-back request held valid is accepted on the `wr_done` cycle.
- Assert `reset` during A_STROBE:
  - `WR`/`CS` high on the next edge; no `wr_done`.
  - `req_ready`=1 afterwards.
  - A following request completes normally.

Source files
------------

// File: rtl/ym3438_host_writer.sv
`default_nettype none
// ============================================================================
// ym3438_host_writer : drives the YM3438 CPU port for address/data register
//                      writes, then optionally polls busy until it clears.
// Revision: 1.0
// ============================================================================
module ym3438_host_writer #(
  parameter int SETUP      = 1,
  parameter int STROBE     = 4,
  parameter int GAP        = 2,
  parameter int POLL_LIMIT = 64
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_port,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_nopoll,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic [1:0] ADDRESS,
  output logic [7:0] DATA,
  input  logic [7:0] DATA_i,
  output logic       wr_done,
  output logic       wr_timeout,
  output logic       busy_seen
);

  localparam logic [7:0]  c_SETUP_LAST  = 8'(SETUP - 1);
  localparam logic [7:0]  c_STROBE_LAST = 8'(STROBE - 1);
  localparam logic [7:0]  c_GAP_LAST    = 8'(GAP - 1);
  localparam logic [15:0] c_POLL_LIMIT  = 16'(POLL_LIMIT);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_A_SETUP  = 4'd1,
    ST_A_STROBE = 4'd2,
    ST_A_GAP    = 4'd3,
    ST_D_SETUP  = 4'd4,
    ST_D_STROBE = 4'd5,
    ST_D_GAP    = 4'd6,
    ST_P_SETUP  = 4'd7,
    ST_P_STROBE = 4'd8,
    ST_P_GAP    = 4'd9
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic [15:0] poll_q, poll_d;
  logic        port_q, port_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        nopoll_q, nopoll_d;
  logic        busy_q, busy_d;
  logic        done_d, timeout_d;
  logic        cs_d, wr_d, rd_d;
  logic [1:0]  address_d;
  logic [7:0]  bus_d;
  logic        w_unused;

  // Only the busy flag of the status byte is meaningful here.
  assign w_unused = ^DATA_i[6:0];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + 8'd1;
    poll_d    = poll_q;
    port_d    = port_q;
    addr_d    = addr_q;
    data_d    = data_q;
    nopoll_d  = nopoll_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = 8'd0;
        if (req_valid) begin
          port_d   = req_port;
          addr_d   = req_addr;
          data_d   = req_data;
          nopoll_d = req_nopoll;
          poll_d   = 16'd0;
          state_d  = ST_A_SETUP;
        end
      end
      ST_A_SETUP:  if (phase_q == c_SETUP_LAST)  begin phase_d = 8'd0; state_d = ST_A_STROBE; end
      ST_A_STROBE: if (phase_q == c_STROBE_LAST) begin phase_d = 8'd0; state_d = ST_A_GAP;    end
      ST_A_GAP:    if (phase_q == c_GAP_LAST)    begin phase_d = 8'd0; state_d = ST_D_SETUP;  end
      ST_D_SETUP:  if (phase_q == c_SETUP_LAST)  begin phase_d = 8'd0; state_d = ST_D_STROBE; end
      ST_D_STROBE: if (phase_q == c_STROBE_LAST) begin phase_d = 8'd0; state_d = ST_D_GAP;    end
      ST_D_GAP: begin
        if (phase_q == c_GAP_LAST) begin
          phase_d = 8'd0;
          if (nopoll_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_P_SETUP;
          end
        end
      end
      ST_P_SETUP:  if (phase_q == c_SETUP_LAST)  begin phase_d = 8'd0; state_d = ST_P_STROBE; end
      ST_P_STROBE: begin
        if (phase_q == c_STROBE_LAST) begin
          phase_d = 8'd0;
          state_d = ST_P_GAP;
          busy_d  = DATA_i[7];
          poll_d  = poll_q + 16'd1;
        end
      end
      ST_P_GAP: begin
        if (phase_q == c_GAP_LAST) begin
          phase_d = 8'd0;
          // The limit check happens before another poll, so poll_q never wraps.
          if (!busy_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (poll_q == c_POLL_LIMIT) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_P_SETUP;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every output is a flop.
  always_comb begin
    cs_d      = !(state_d inside {ST_A_SETUP, ST_A_STROBE, ST_D_SETUP, ST_D_STROBE,
                                  ST_P_SETUP, ST_P_STROBE});
    wr_d      = !(state_d inside {ST_A_STROBE, ST_D_STROBE});
    rd_d      = (state_d != ST_P_STROBE);
    address_d = ADDRESS;
    bus_d     = DATA;
    case (state_d)
      ST_A_SETUP: begin address_d = {port_d, 1'b0}; bus_d = addr_d; end
      ST_D_SETUP: begin address_d = {port_d, 1'b1}; bus_d = data_d; end
      ST_P_SETUP: address_d = 2'b00;
      default: ;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= 8'd0;
      poll_q     <= 16'd0;
      port_q     <= 1'b0;
      addr_q     <= 8'd0;
      data_q     <= 8'd0;
      nopoll_q   <= 1'b0;
      busy_q     <= 1'b0;
      req_ready  <= 1'b1;
      CS         <= 1'b1;
      WR         <= 1'b1;
      RD         <= 1'b1;
      ADDRESS    <= 2'b00;
      DATA       <= 8'd0;
      wr_done    <= 1'b0;
      wr_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      poll_q     <= poll_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      nopoll_q   <= nopoll_d;
      busy_q     <= busy_d;
      req_ready  <= (state_d == ST_IDLE);
      CS         <= cs_d;
      WR         <= wr_d;
      RD         <= rd_d;
      ADDRESS    <= address_d;
      DATA       <= bus_d;
      wr_done    <= done_d;
      wr_timeout <= timeout_d;
    end
  end

  assign busy_seen = busy_q;

endmodule
`default_nettype wire
